mood_engine: RTL and testbench
==============================

// Module: mood_engine
// PURPOSE
//  Parametrised drive/mood core: CHANNELS saturating drive counters (ch0 = energy, ch1 = stress, others free).
//  Counters update only on an internal heartbeat tick of programmable rate.
//  A physical-state FSM (AWAKE/ASLEEP/DYING/DEAD) auto-regulates ch0/ch1.
//  Sits between stimulus decoding and the emotion/output logic of the top level.
// PARAMETERS
//  CHANNELS    3                  number of drive counters (>=2)
//  WIDTH       7                  counter width; MAX = 2^WIDTH-1
//  DIV_BITS    4                  tick divider width; tick period P = 2^(DIV_BITS-rate)
//  RESET_VALS  {7'd64,7'd40,7'd96} packed CHANNELS*WIDTH reset values, ch0 in LSBs
//  GRACE_TICKS 8                  ticks spent in DYING with ch0==0 before DEAD (1..255)
// PORTS
//  clk          in   1              clock
//  rst_n        in   1              asynchronous active-low reset
//  ena          in   1              global advance enable; 0 freezes all state, tick=0
//  rate         in   2              heartbeat rate; 0 slowest; must satisfy rate < DIV_BITS
//  inc          in   CHANNELS       per-channel increment request, sampled on tick
//  dec          in   CHANNELS       per-channel decrement request, sampled on tick
//  load         in   1              load strobe, sampled on tick
//  load_sel     in   CHANNELS       one-hot channel select for load
//  load_val     in   WIDTH          load value
//  tick         out  1              registered one-cycle heartbeat pulse
//  value        out  CHANNELS*WIDTH counter values, ch0 in LSBs
//  level        out  CHANNELS*2     per channel value[WIDTH-1:WIDTH-2], combinational
//  state        out  2              00 AWAKE, 01 ASLEEP, 10 DYING, 11 DEAD
//  fell_asleep  out  1              one-cycle pulse on entry to ASLEEP
//  woke_up      out  1              one-cycle pulse on ASLEEP->AWAKE
// BEHAVIOUR
//  Reset (async, immediate):
//   - div counter 0, tick 0, value = RESET_VALS, state AWAKE, pulses 0, grace counter 0.
//  Divider:
//   - cnt += 1 on every clk with ena=1; rate changes take effect immediately, cnt is not cleared.
//   - mask = 2^(DIV_BITS-rate)-1; tick <= ena & ((cnt & mask) == mask).
//   - With ena held high, the first tick is high in the cycle after the P-th enabled edge.
//  Update edge = rising clk with tick=1 and ena=1. Counters and FSM advance only on update edges.
//  Per-channel counter update, in priority order:
//   1. DEAD: hold; load, inc and dec are all ignored.
//   2. load & load_sel[i]: value = load_val.
//   3. Forced: ASLEEP ch0 +1, ch1 -1; external inc/dec on ch0/ch1 ignored.
//   4. External: inc&!dec -> +1; dec&!inc -> -1; both or neither -> hold.
//   - Saturate at MAX and at 0; no wrap-around.
//  FSM (on update edges, decided from pre-update values, same edge as counter update):
//   - AWAKE:  ch0==0 -> DYING (grace cleared); else level0==0 -> ASLEEP (fell_asleep=1 next cycle).
//   - ASLEEP: ch0==MAX -> AWAKE (woke_up=1 next cycle).
//   - DYING:  ch0!=0 -> AWAKE; else grace+1, and if grace reaches GRACE_TICKS-1 -> DEAD.
//   - DEAD:   terminal; only rst_n leaves it.
//  Outputs:
//   - fell_asleep and woke_up are high exactly one cycle, registered alongside state.
//   - tick stays active in DEAD; value and level hold their frozen values.
// TESTING
//  T1 reset: release rst_n, ena=1, rate=3 -> value ch0/1/2 = 96/40/64, AWAKE; tick on every 2nd cycle.
//  T2 saturation: load ch1=126, inc ch1 for 3 ticks -> 127 held; inc+dec on ch2 at 64 -> 64 held.
//  T3 sleep: load ch0=31 -> next tick ASLEEP, fell_asleep 1 cycle; ch0 +1/tick, ch1 -1/tick to 0;
//     one tick after ch0 = 127 -> AWAKE, woke_up pulse.
//  T4 death: load ch0=0 -> DYING next tick; 8 ticks with no inc -> DEAD; load and inc then ignored.
//  T5 rescue: in DYING, inc ch0 on a tick -> ch0=1; next tick AWAKE, grace cleared.
//  T6 async reset and ena: rst_n low mid-DYING, between clk edges -> defaults at once;
//     ena=0 for 20 cycles -> no tick, no change.

Source files
------------

// File: rtl/mood_engine.sv
// mood_engine: heartbeat-ticked saturating drive counters regulated by an AWAKE/ASLEEP/DYING/DEAD FSM
module mood_engine #(
  parameter int CHANNELS = 3,
  parameter int WIDTH = 7,
  parameter int DIV_BITS = 4,
  parameter logic [CHANNELS*WIDTH-1:0] RESET_VALS = {7'd64, 7'd40, 7'd96},
  parameter int GRACE_TICKS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [1:0]                rate,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic                      load,
  input  logic [CHANNELS-1:0]       load_sel,
  input  logic [WIDTH-1:0]          load_val,
  output logic                      tick,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS*2-1:0]     level,
  output logic [1:0]                state,
  output logic                      fell_asleep,
  output logic                      woke_up
);
  typedef enum logic [1:0] {AWAKE = 2'b00, ASLEEP = 2'b01, DYING = 2'b10, DEAD = 2'b11} st_t;
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [7:0] GLAST = 8'(GRACE_TICKS - 1);
  st_t st;
  logic [DIV_BITS-1:0] cnt, mask;
  logic [7:0] grace;
  logic [WIDTH-1:0] ch0;
  logic upd;
  assign mask = {DIV_BITS{1'b1}} >> rate;
  assign upd = tick & ena;
  assign ch0 = value[WIDTH-1:0];
  assign state = st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= ena ? cnt + 1'b1 : cnt;
      tick <= ena & ((cnt & mask) == mask);
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] v, nv;
    logic f, up, dn;
    always_comb begin
      f = st == ASLEEP && i < 2;
      up = f ? i == 0 : inc[i] & ~dec[i];
      dn = f ? i == 1 : dec[i] & ~inc[i];
      nv = load & load_sel[i] ? load_val : up && v != MAX ? v + 1'b1 : dn && v != '0 ? v - 1'b1 : v;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) v <= RESET_VALS[i*WIDTH +: WIDTH];
      else if (upd && st != DEAD) v <= nv;
    assign value[i*WIDTH +: WIDTH] = v;
    assign level[2*i +: 2] = v[WIDTH-1 -: 2];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= AWAKE;
      grace <= '0;
      fell_asleep <= 1'b0;
      woke_up <= 1'b0;
    end else begin
      fell_asleep <= upd && st == AWAKE && ch0 != '0 && ch0[WIDTH-1 -: 2] == 2'b00;
      woke_up <= upd && st == ASLEEP && ch0 == MAX;
      if (upd)
        case (st)
          AWAKE:
            if (ch0 == '0) begin
              st <= DYING;
              grace <= '0;
            end else if (ch0[WIDTH-1 -: 2] == 2'b00) st <= ASLEEP;
          ASLEEP: if (ch0 == MAX) st <= AWAKE;
          DYING:
            if (ch0 != '0) begin
              st <= AWAKE;
              grace <= '0;
            end else if (grace == GLAST) st <= DEAD;
            else grace <= grace + 1'b1;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_mood_engine.sv
// tb_mood_engine: directed and randomized checks of mood_engine against a behavioural model
module tb_mood_engine;
  localparam int DIV_BITS = 4;
  localparam int GRACE = 8;
  localparam int MAXV = 127;
  localparam int AWAKE = 0, ASLEEP = 1, DYING = 2, DEAD = 3;
  localparam logic [20:0] RST_VAL = {7'd64, 7'd40, 7'd96};
  localparam logic [5:0] RST_LVL = {2'd2, 2'd1, 2'd3};

  logic clk = 0, rst_n = 0, ena = 0, load = 0;
  logic [1:0] rate = 0;
  logic [2:0] inc = 0, dec = 0, load_sel = 0;
  logic [6:0] load_val = 0;
  logic tick, fell_asleep, woke_up;
  logic [20:0] value;
  logic [5:0] level;
  logic [1:0] state;

  int errors = 0, checks = 0;
  int mv[3];
  int mst, mdy, mcnt;
  bit mtick, mfell, mwoke, last_upd;

  mood_engine dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rate(rate), .inc(inc), .dec(dec),
    .load(load), .load_sel(load_sel), .load_val(load_val), .tick(tick), .value(value),
    .level(level), .state(state), .fell_asleep(fell_asleep), .woke_up(woke_up)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] mval();
    return {7'(mv[2]), 7'(mv[1]), 7'(mv[0])};
  endfunction

  function automatic logic [5:0] mlvl();
    return {2'(mv[2] / 32), 2'(mv[1] / 32), 2'(mv[0] / 32)};
  endfunction

  task automatic model_reset();
    mv[0] = 96; mv[1] = 40; mv[2] = 64;
    mst = AWAKE; mdy = 0; mcnt = 0;
    mtick = 0; mfell = 0; mwoke = 0;
  endtask

  // One rising edge of the reference: heartbeat period, drive arithmetic and life-state rules
  task automatic model_edge();
    int p, d;
    int nv[3];
    bit up, nt;
    if (!rst_n) return;
    up = mtick && ena;
    last_upd = up;
    p = 1 << (DIV_BITS - int'(rate));
    nt = ena && (mcnt % p == p - 1);
    if (ena) mcnt = (mcnt + 1) % (1 << DIV_BITS);
    mfell = 0; mwoke = 0;
    if (up && mst != DEAD) begin
      for (int c = 0; c < 3; c++) begin
        if (load && load_sel[c]) nv[c] = int'(load_val);
        else begin
          d = (mst == ASLEEP && c < 2) ? (c == 0 ? 1 : -1) : int'(inc[c]) - int'(dec[c]);
          nv[c] = mv[c] + d;
          if (nv[c] > MAXV) nv[c] = MAXV;
          if (nv[c] < 0) nv[c] = 0;
        end
      end
      case (mst)
        AWAKE: if (mv[0] == 0) begin mst = DYING; mdy = 0; end
               else if (mv[0] < 32) begin mst = ASLEEP; mfell = 1; end
        ASLEEP: if (mv[0] == MAXV) begin mst = AWAKE; mwoke = 1; end
        DYING: if (mv[0] != 0) mst = AWAKE;
               else begin mdy++; if (mdy == GRACE) mst = DEAD; end
        default: ;
      endcase
      for (int c = 0; c < 3; c++) mv[c] = nv[c];
    end
    mtick = nt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick_edge();
    int n = 0;
    last_upd = 0;
    do begin step(); n++; end while (!last_upd && n < 64);
    if (!last_upd) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no update edge within %0d cycles", n);
    end
  endtask

  task automatic do_load(input logic [2:0] sel, input logic [6:0] val);
    load = 1; load_sel = sel; load_val = val;
    tick_edge();
    load = 0;
  endtask

  task automatic test_reset();
    int ones = 0;
    rst_n = 0; ena = 1; rate = 3;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++; if (value !== RST_VAL) begin errors++; $display("FAIL reset_value: got %h expected %h", value, RST_VAL); end
    checks++; if (level !== RST_LVL) begin errors++; $display("FAIL reset_level: got %b expected %b", level, RST_LVL); end
    checks++; if ({state, tick, fell_asleep, woke_up} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {state, tick, fell_asleep, woke_up}); end
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      ones += int'(tick);
      checks++; if (tick !== (k % 2 == 1) || tick !== mtick) begin errors++; $display("FAIL tick_pattern[%0d]: got %b expected %b", k, tick, mtick); end
    end
    checks++; if (ones != 4) begin errors++; $display("FAIL tick_count: got %0d expected 4", ones); end
  endtask

  task automatic test_saturation();
    do_load(3'b010, 7'd126);
    inc = 3'b010;
    repeat (3) tick_edge();
    checks++; if (value[13:7] !== 7'd127 || value !== mval()) begin errors++; $display("FAIL sat_high: got %h expected %h", value, mval()); end
    inc = 3'b100; dec = 3'b100;
    repeat (2) tick_edge();
    checks++; if (value[20:14] !== 7'd64) begin errors++; $display("FAIL inc_dec_hold: got %0d expected 64", value[20:14]); end
    inc = 3'b000;
    tick_edge();
    checks++; if (value[20:14] !== 7'd63) begin errors++; $display("FAIL dec_ch2: got %0d expected 63", value[20:14]); end
    dec = 3'b000;
    do_load(3'b010, 7'd1);
    dec = 3'b010;
    repeat (3) tick_edge();
    dec = 3'b000;
    checks++; if (value[13:7] !== 7'd0 || value !== mval()) begin errors++; $display("FAIL sat_low: got %h expected %h", value, mval()); end
  endtask

  task automatic test_sleep();
    do_load(3'b010, 7'd50);
    do_load(3'b001, 7'd31);
    checks++; if (state !== 2'd0 || value[6:0] !== 7'd31) begin errors++; $display("FAIL sleep_load: got state %0d ch0 %0d expected 0/31", state, value[6:0]); end
    tick_edge();
    checks++; if (state !== 2'd1 || fell_asleep !== 1'b1 || !mfell) begin errors++; $display("FAIL sleep_entry: got state %0d fell %b expected 1/1", state, fell_asleep); end
    checks++; if (level[1:0] !== 2'd0) begin errors++; $display("FAIL sleep_level: got %0d expected 0", level[1:0]); end
    step();
    checks++; if (fell_asleep !== 1'b0) begin errors++; $display("FAIL fell_pulse_width: got %b expected 0", fell_asleep); end
    for (int n = 0; n < 120 && mst == ASLEEP; n++) begin
      inc = 3'($urandom); dec = 3'($urandom);
      tick_edge();
      checks++; if (value !== mval() || state !== 2'(mst)) begin errors++; $display("FAIL sleep_track[%0d]: got %h/%0d expected %h/%0d", n, value, state, mval(), mst); end
    end
    inc = 0; dec = 0;
    checks++; if (state !== 2'd0 || woke_up !== 1'b1 || value[13:0] !== {7'd0, 7'd127}) begin errors++; $display("FAIL wake: got state %0d woke %b ch1/ch0 %0d/%0d expected 0/1/0/127", state, woke_up, value[13:7], value[6:0]); end
    step();
    checks++; if (woke_up !== 1'b0) begin errors++; $display("FAIL woke_pulse_width: got %b expected 0", woke_up); end
  endtask

  task automatic test_rescue();
    do_load(3'b001, 7'd0);
    tick_edge();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rescue_dying: got %0d expected 2", state); end
    repeat (3) tick_edge();
    inc = 3'b001;
    tick_edge();
    inc = 0;
    checks++; if (state !== 2'd2 || value[6:0] !== 7'd1) begin errors++; $display("FAIL rescue_inc: got state %0d ch0 %0d expected 2/1", state, value[6:0]); end
    do_load(3'b001, 7'd100);
    checks++; if (state !== 2'd0 || value[6:0] !== 7'd100 || state !== 2'(mst)) begin errors++; $display("FAIL rescue_awake: got state %0d ch0 %0d expected 0/100", state, value[6:0]); end
  endtask

  task automatic test_death();
    logic [20:0] snap;
    int ones = 0;
    do_load(3'b001, 7'd0);
    dec = 3'b100;
    tick_edge();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL death_dying: got %0d expected 2", state); end
    for (int k = 1; k <= 8; k++) begin
      tick_edge();
      checks++; if (state !== (k < 8 ? 2'd2 : 2'd3) || state !== 2'(mst) || value !== mval()) begin errors++; $display("FAIL grace[%0d]: got state %0d value %h expected %0d/%h", k, state, value, mst, mval()); end
    end
    dec = 0;
    snap = value;
    load = 1; load_sel = 3'b001; load_val = 7'd50; inc = 3'b111;
    for (int k = 0; k < 8; k++) begin step(); ones += int'(tick); end
    load = 0; inc = 0;
    checks++; if (value !== snap || state !== 2'd3) begin errors++; $display("FAIL dead_frozen: got %h/%0d expected %h/3", value, state, snap); end
    checks++; if (ones != 4) begin errors++; $display("FAIL dead_tick: got %0d ticks expected 4", ones); end
  endtask

  task automatic test_async_ena();
    logic [20:0] snap;
    rst_n = 0; model_reset(); step(); rst_n = 1;
    do_load(3'b001, 7'd0);
    repeat (2) tick_edge();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL async_pre: got %0d expected 2", state); end
    @(posedge clk);
    model_edge();
    #3;
    rst_n = 0;
    #1;
    model_reset();
    checks++; if (value !== RST_VAL || state !== 2'd0 || tick !== 1'b0) begin errors++; $display("FAIL async_reset: got %h/%0d/%b expected %h/0/0", value, state, tick, RST_VAL); end
    step();
    checks++; if (value !== mval() || tick !== 1'b0) begin errors++; $display("FAIL async_hold: got %h/%b expected %h/0", value, tick, mval()); end
    rst_n = 1;
    do_load(3'b100, 7'd77);
    ena = 0; inc = 3'b111; snap = value;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++; if (tick !== 1'b0 || value !== snap || value !== mval()) begin errors++; $display("FAIL ena_freeze[%0d]: got tick %b value %h expected 0/%h", k, tick, value, snap); end
    end
    ena = 1; inc = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 2500; k++) begin
      ena = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 49) == 0) rate = 2'($urandom_range(0, 3));
      inc = 3'($urandom); dec = 3'($urandom);
      load = $urandom_range(0, 19) == 0;
      load_sel = 3'(1 << $urandom_range(0, 2));
      load_val = 7'($urandom);
      if (mst == DEAD && $urandom_range(0, 9) == 0) begin rst_n = 0; model_reset(); end
      else rst_n = 1;
      step();
      checks++; if (value !== mval() || level !== mlvl()) begin errors++; $display("FAIL rand_value[%0d]: got %h/%b expected %h/%b", k, value, level, mval(), mlvl()); end
      checks++; if ({tick, state, fell_asleep, woke_up} !== {mtick, 2'(mst), mfell, mwoke}) begin errors++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", k, {tick, state, fell_asleep, woke_up}, {mtick, 2'(mst), mfell, mwoke}); end
    end
    rst_n = 1; load = 0; inc = 0; dec = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_saturation();
    test_sleep();
    test_rescue();
    test_death();
    test_async_ena();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
